// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: shared types and constants for the interrupt request side of the core.
package int_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, PULSE, WAIT} state_t;

    localparam int NUM_SRC_DEF = 4;
    localparam int IDX_W_DEF   = 2;
    localparam int CNT_W       = 3;

    // Fetch forms the ISR address as VEC_BASE + vec_idx.
    localparam logic [15:0] VEC_BASE = 16'h0010;

    function automatic logic [15:0] isr_addr(input logic [15:0] idx);
        return VEC_BASE + idx;
    endfunction

endpackage

// File: rtl/prio_encoder_lsb.sv
// prio_encoder_lsb: lowest-set-bit encoder; bit 0 has the highest priority.
module prio_encoder_lsb #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         valid
);

    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[i]) idx = W'(i);
    end

    assign valid = |req;

endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: latches edge requests as pending bits, issues one fixed-priority
// interrupt pulse with a vector index, and blocks further requests until RTI retires.
module interrupt_controller
    import int_ctrl_pkg::*;
#(
    parameter int NUM_SRC   = NUM_SRC_DEF,
    parameter int PULSE_LEN = 1,
    parameter int IDX_W     = IDX_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [NUM_SRC-1:0] irq_mask,
    input  logic               global_en,
    input  logic               flush,
    input  logic               rti_done,
    output logic               interrupt,
    output logic [IDX_W-1:0]   vec_idx,
    output logic [NUM_SRC-1:0] pending,
    output logic               in_service
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_SRC-1:0] prev;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] clr;
    logic [IDX_W-1:0]   sel;
    logic               valid;
    logic               accept;

    assign rise   = irq_src & ~prev;
    assign cand   = pending & ~irq_mask;
    assign accept = (state == IDLE) && valid && global_en && !flush;
    assign clr    = accept ? (NUM_SRC'(1) << sel) : '0;

    prio_encoder_lsb #(.N(NUM_SRC), .W(IDX_W)) u_prio (
        .req   (cand),
        .idx   (sel),
        .valid (valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            prev       <= '0;
            pending    <= '0;
            interrupt  <= 1'b0;
            vec_idx    <= '0;
            in_service <= 1'b0;
        end else begin
            prev    <= irq_src;
            // A fresh edge on the bit being cleared is a new request, so it stays pending.
            pending <= (pending & ~clr) | rise;
            case (state)
                IDLE: if (accept) begin
                    state      <= PULSE;
                    interrupt  <= 1'b1;
                    in_service <= 1'b1;
                    vec_idx    <= sel;
                    cnt        <= CNT_W'(PULSE_LEN - 1);
                end
                PULSE: if (cnt == '0) begin
                    state     <= WAIT;
                    interrupt <= 1'b0;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                WAIT: if (rti_done) begin
                    state      <= IDLE;
                    in_service <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
